regfile_stage: RTL and testbench
================================

# regfile_stage

Register-read stage between the decoder and the execute units. It accepts decoded instructions (`idrf_tdata_t`) on an AXI-Stream slave and reads `rs1`/`rs2` from a 32×32 integer register file. It forwards each instruction with its operand values to execute (`rfex_tdata_t`) through a two-entry skid buffer. It owns the architectural register array and the write-back port into it.

## Interface
- `XLEN`, default 32: register and operand width.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `idrf_axis_if`  axis_if.s  `$bits(idrf_tdata_t)`  decoded instruction from the decoder FIFO.
- `rfex_axis_if`  axis_if.m  `$bits(rfex_tdata_t)`  `{id_data, rs1_data[XLEN-1:0], rs2_data[XLEN-1:0]}` to execute.
- `wb_vld`  in  1  write-back strobe.
- `wb_rd`  in  5  write-back destination.
- `wb_data`  in  XLEN  write-back value.
- `invalidate`  in  1  pipeline flush.

## Operation
- Register array `x1..x31`; `x0` is not stored and always reads 0.
- Write-back: when `wb_vld && wb_rd != 0`, the array is written at the clock edge. Writes to `x0` are ignored.
- Read: `rs1_data`/`rs2_data` are taken from `idrf_tdata.rs1/rs2` combinationally in the capture cycle. `id_data` passes through unmodified, including the `fwd_*` flags and `if_data`.
- Skid buffer: main entry M drives `rfex_axis_if`; skid entry S holds a captured beat when M is stalled.
  - States: EMPTY (M and S empty), ONE (M valid), FULL (M and S valid).
  - EMPTY→ONE on input handshake.
  - ONE→ONE on in+out handshake in the same cycle.
  - ONE→EMPTY on output handshake only.
  - ONE→FULL on input handshake while output is stalled.
  - FULL→ONE on output handshake: S moves to M.
- Operand refresh: in every cycle, each valid entry whose `rs1` (or `rs2`) is nonzero and equals `wb_rd` with `wb_vld` high replaces its stored operand with `wb_data`. This keeps held operands coherent with the array.
- Flush: when `invalidate` is high, M and S are cleared at the next edge and the state becomes EMPTY. A beat offered in that cycle is dropped even if `tready` was high. The register array and the write-back in that cycle are unaffected.
- Simultaneous write-back and capture to the same register: see Configuration.

## Timing
- Reset values:
  - `rfex_axis_if.tvalid` = 0.
  - `rfex_axis_if.tdata` = 0.
  - `idrf_axis_if.tready` = 1.
  - All array registers = 0.
  - State = EMPTY.
- Latency: 1 cycle from input handshake to `rfex_axis_if.tvalid`.
- Throughput: 1 beat per cycle when execute is ready.
- `idrf_axis_if.tready` is registered and equals `!S.valid`; there is no combinational path from `rfex_axis_if.tready` to it.
- `rfex_axis_if.tvalid`/`tdata` are driven only from registers.
- `rfex_axis_if.tvalid`/`tdata` stay stable until handshake, except for operand refresh and flush.
- Write-back data appears in an array read one cycle after `wb_vld`.

## Configuration
- `OFFNARISCV_RF_BYPASS_EN` defined: a capture in the same cycle as a matching write-back (`wb_vld`, `wb_rd != 0`, `wb_rd == rs1/rs2`) takes `wb_data` for that operand. No stall is introduced.
- `OFFNARISCV_RF_BYPASS_EN` undefined: no bypass mux. `idrf_axis_if.tready` is additionally forced low in any cycle where `wb_vld && wb_rd != 0 && wb_rd` matches a nonzero `rs1` or `rs2` of the offered beat. Capture therefore occurs in the next cycle from the updated array, and tready is no longer purely registered.

## Test plan
- Reset, then offer `rs1=0, rs2=0` -> next cycle `rfex tvalid=1`, `rs1_data=rs2_data=0`, `id_data` equal to the input beat.
- `wb_vld=1, wb_rd=5, wb_data=0x1234_5678`; two cycles later offer `rs1=5, rs2=0` -> `rs1_data=0x1234_5678`, `rs2_data=0`.
- Same-cycle `wb_rd=7, wb_data=0xDEAD_BEEF` and capture with `rs2=7`:
  - With bypass -> `rs2_data=0xDEAD_BEEF`, captured in that cycle.
  - Without bypass -> `tready=0` for that cycle, then capture with `0xDEAD_BEEF`.
- Hold `rfex tready=0`, push beats A and B -> `idrf tready` drops after B. While held, `wb_rd=3, wb_data=0x55` with B.`rs1=3` -> after release, A then B emerge in order with B.`rs1_data=0x55`.
- `wb_vld=1, wb_rd=0, wb_data=0xFFFF_FFFF`, then read `rs1=0` -> `rs1_data=0`.
- FULL state with `invalidate` pulsed for 1 cycle -> next cycle `rfex tvalid=0`, `idrf tready=1`. Earlier write-backs are still present in the array.

Source files
------------

// File: rtl/regfile_stage.sv
// regfile_stage: register-read stage with a 32 x XLEN integer register file and a 2-entry skid buffer.
// idrf_tdata[4:0]=rs1, [9:5]=rs2, other bits opaque. Define OFFNARISCV_RF_BYPASS_EN for same-cycle write-back bypass.
module regfile_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ID_W = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     idrf_tvalid,
  output logic                     idrf_tready,
  input  logic [ID_W-1:0]          idrf_tdata,
  output logic                     rfex_tvalid,
  input  logic                     rfex_tready,
  output logic [ID_W+2*XLEN-1:0]   rfex_tdata,
  input  logic                     wb_vld,
  input  logic [4:0]               wb_rd,
  input  logic [XLEN-1:0]          wb_data,
  input  logic                     invalidate
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
  } entry_t;

  state_e          state_q, state_d;
  entry_t          m_q, m_d, s_q, s_d, cap;
  logic [XLEN-1:0] rf_q [32];
  logic [XLEN-1:0] rf_d [32];
  logic [4:0]      in_rs1, in_rs2;
  logic            wb_hit, hazard, in_hs, out_hs, s_valid;

  // Held operands track write-backs so a stalled beat never carries a stale value.
  function automatic entry_t refresh(input entry_t e, input logic hit,
                                     input logic [4:0] rd, input logic [XLEN-1:0] d);
    entry_t r;
    r = e;
    if (hit && e.id[4:0] == rd) r.rs1 = d;
    if (hit && e.id[9:5] == rd) r.rs2 = d;
    return r;
  endfunction

  assign in_rs1  = idrf_tdata[4:0];
  assign in_rs2  = idrf_tdata[9:5];
  assign wb_hit  = wb_vld && (wb_rd != 5'd0);
  assign s_valid = (state_q == FULL);

`ifdef OFFNARISCV_RF_BYPASS_EN
  assign hazard = 1'b0;

  always_comb begin
    cap.id  = idrf_tdata;
    cap.rs1 = (wb_hit && wb_rd == in_rs1) ? wb_data : rf_q[in_rs1];
    cap.rs2 = (wb_hit && wb_rd == in_rs2) ? wb_data : rf_q[in_rs2];
  end
`else
  // wb_hit excludes x0, so a match here always involves a nonzero source register.
  assign hazard = idrf_tvalid && wb_hit && (wb_rd == in_rs1 || wb_rd == in_rs2);

  always_comb begin
    cap.id  = idrf_tdata;
    cap.rs1 = rf_q[in_rs1];
    cap.rs2 = rf_q[in_rs2];
  end
`endif

  assign idrf_tready = !s_valid && !hazard;
  assign in_hs       = idrf_tvalid && idrf_tready;
  assign rfex_tvalid = (state_q != EMPTY);
  assign rfex_tdata  = m_q;
  assign out_hs      = rfex_tvalid && rfex_tready;

  always_comb begin
    rf_d = rf_q;
    if (wb_hit) rf_d[wb_rd] = wb_data;
    rf_d[0] = '0;
  end

  always_comb begin
    state_d = state_q;
    m_d     = refresh(m_q, wb_hit, wb_rd, wb_data);
    s_d     = refresh(s_q, wb_hit, wb_rd, wb_data);
    if (invalidate) begin
      state_d = EMPTY;
      m_d     = '0;
      s_d     = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_hs) begin
            m_d     = cap;
            state_d = ONE;
          end
        end
        ONE: begin
          case ({in_hs, out_hs})
            2'b11:   m_d = cap;
            2'b01:   state_d = EMPTY;
            2'b10: begin
              s_d     = cap;
              state_d = FULL;
            end
            default: ;
          endcase
        end
        FULL: begin
          if (out_hs) begin
            m_d     = s_d;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      m_q     <= '0;
      s_q     <= '0;
      for (int unsigned i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
      rf_q    <= rf_d;
    end
  end

endmodule

// File: tb/tb_regfile_stage.sv
// Self-checking bench for regfile_stage: directed scenarios plus randomized traffic against a queue/array model.
module tb_regfile_stage;
  localparam int XLEN = 32;
  localparam int ID_W = 64;
  localparam int TW   = ID_W + 2 * XLEN;

  logic            clk = 1'b0;
  logic            rst;
  logic            idrf_tvalid, idrf_tready, rfex_tvalid, rfex_tready;
  logic [ID_W-1:0] idrf_tdata;
  logic [TW-1:0]   rfex_tdata;
  logic            wb_vld, invalidate;
  logic [4:0]      wb_rd;
  logic [31:0]     wb_data;

  regfile_stage #(.XLEN(XLEN), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .idrf_tvalid(idrf_tvalid), .idrf_tready(idrf_tready), .idrf_tdata(idrf_tdata),
    .rfex_tvalid(rfex_tvalid), .rfex_tready(rfex_tready), .rfex_tdata(rfex_tdata),
    .wb_vld(wb_vld), .wb_rd(wb_rd), .wb_data(wb_data), .invalidate(invalidate)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [31:0]     r1;
    logic [31:0]     r2;
  } ent_t;

  ent_t        q[$];
  logic [31:0] rf[32];
  int          checks = 0;
  int          errors = 0;
  logic        exp_tready, exp_tvalid, obs_tready, obs_tvalid;
  logic [TW-1:0] exp_tdata, obs_tdata;

  function automatic logic [ID_W-1:0] mk_id(input logic [4:0] r1, input logic [4:0] r2);
    logic [ID_W-1:0] v;
    v = {$urandom, $urandom};
    v[4:0] = r1;
    v[9:5] = r2;
    return v;
  endfunction

  function automatic bit blocked();
`ifdef OFFNARISCV_RF_BYPASS_EN
    return 1'b0;
`else
    return idrf_tvalid && wb_vld && wb_rd != 0 &&
           (wb_rd == idrf_tdata[4:0] || wb_rd == idrf_tdata[9:5]);
`endif
  endfunction

  function automatic logic [31:0] rd_val(input logic [4:0] r);
    logic [31:0] v;
    v = (r == 0) ? 32'h0 : rf[r];
`ifdef OFFNARISCV_RF_BYPASS_EN
    if (wb_vld && wb_rd != 0 && wb_rd == r) v = wb_data;
`endif
    return v;
  endfunction

  // Samples DUT and model at the falling edge, then advances the model across the rising edge.
  task automatic tick();
    ent_t e;
    bit   in_hs, out_hs;
    @(negedge clk);
    exp_tready = (q.size() < 2) && !blocked();
    exp_tvalid = (q.size() != 0);
    exp_tdata  = exp_tvalid ? {q[0].id, q[0].r1, q[0].r2} : '0;
    obs_tready = idrf_tready;
    obs_tvalid = rfex_tvalid;
    obs_tdata  = rfex_tdata;
    in_hs  = idrf_tvalid && exp_tready;
    out_hs = exp_tvalid && rfex_tready;
    if (invalidate) q.delete();
    else begin
      if (out_hs) void'(q.pop_front());
      foreach (q[i]) begin
        if (wb_vld && wb_rd != 0 && q[i].id[4:0] == wb_rd) q[i].r1 = wb_data;
        if (wb_vld && wb_rd != 0 && q[i].id[9:5] == wb_rd) q[i].r2 = wb_data;
      end
      if (in_hs) begin
        e.id = idrf_tdata;
        e.r1 = rd_val(idrf_tdata[4:0]);
        e.r2 = rd_val(idrf_tdata[9:5]);
        q.push_back(e);
      end
    end
    if (wb_vld && wb_rd != 0) rf[wb_rd] = wb_data;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; idrf_tvalid = 0; idrf_tdata = '0; rfex_tready = 0;
    wb_vld = 0; wb_rd = 0; wb_data = 0; invalidate = 0;
    q.delete();
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (rfex_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", rfex_tvalid); end
    checks++; if (rfex_tdata !== '0) begin errors++; $display("FAIL reset_tdata: got %h expected 0", rfex_tdata); end
    checks++; if (idrf_tready !== 1'b1) begin errors++; $display("FAIL reset_tready: got %b expected 1", idrf_tready); end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_zero_read();
    logic [ID_W-1:0] a, b;
    a = mk_id(5'd0, 5'd0);
    b = mk_id(5'd31, 5'd1);
    rfex_tready = 1;
    idrf_tvalid = 1; idrf_tdata = a;
    tick();
    checks++; if (obs_tready !== 1'b1) begin errors++; $display("FAIL zero_tready: got %b expected 1", obs_tready); end
    idrf_tdata = b;
    tick();
    checks++; if (obs_tvalid !== 1'b1) begin errors++; $display("FAIL zero_tvalid: got %b expected 1", obs_tvalid); end
    checks++; if (obs_tdata !== {a, 64'h0}) begin errors++; $display("FAIL zero_tdata: got %h expected %h", obs_tdata, {a, 64'h0}); end
    idrf_tvalid = 0;
    tick();
    checks++; if (obs_tdata !== {b, 64'h0} || obs_tvalid !== 1'b1) begin errors++; $display("FAIL reset_array_b2b: got %h expected %h", obs_tdata, {b, 64'h0}); end
    tick();
    checks++; if (obs_tvalid !== 1'b0) begin errors++; $display("FAIL zero_drain: got %b expected 0", obs_tvalid); end
  endtask

  task automatic test_writeback();
    logic [ID_W-1:0] a;
    a = mk_id(5'd5, 5'd0);
    wb_vld = 1; wb_rd = 5; wb_data = 32'h1234_5678;
    tick();
    wb_vld = 0;
    tick();
    idrf_tvalid = 1; idrf_tdata = a;
    tick();
    idrf_tvalid = 0;
    tick();
    checks++; if (obs_tdata !== {a, 32'h1234_5678, 32'h0} || obs_tvalid !== 1'b1) begin errors++; $display("FAIL wb_read: got %h expected %h", obs_tdata, {a, 32'h1234_5678, 32'h0}); end
  endtask

  task automatic test_same_cycle();
    logic [ID_W-1:0] a;
    a = mk_id(5'd0, 5'd7);
    wb_vld = 1; wb_rd = 7; wb_data = 32'hDEAD_BEEF;
    idrf_tvalid = 1; idrf_tdata = a;
    tick();
    wb_vld = 0;
`ifdef OFFNARISCV_RF_BYPASS_EN
    checks++; if (obs_tready !== 1'b1) begin errors++; $display("FAIL bypass_tready: got %b expected 1", obs_tready); end
`else
    checks++; if (obs_tready !== 1'b0) begin errors++; $display("FAIL hazard_tready: got %b expected 0", obs_tready); end
    tick();
    checks++; if (obs_tready !== 1'b1 || obs_tvalid !== 1'b0) begin errors++; $display("FAIL hazard_retry: got tready=%b tvalid=%b expected 1 0", obs_tready, obs_tvalid); end
`endif
    idrf_tvalid = 0;
    tick();
    checks++; if (obs_tdata !== {a, 32'h0, 32'hDEAD_BEEF} || obs_tvalid !== 1'b1) begin errors++; $display("FAIL same_cycle_rs2: got %h expected %h", obs_tdata, {a, 32'h0, 32'hDEAD_BEEF}); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [ID_W-1:0] a, b;
    a = mk_id(5'd10, 5'd0);
    b = mk_id(5'd3, 5'd0);
    rfex_tready = 0;
    idrf_tvalid = 1; idrf_tdata = a;
    tick();
    idrf_tdata = b;
    tick();
    checks++; if (obs_tready !== 1'b1) begin errors++; $display("FAIL bp_tready_one: got %b expected 1", obs_tready); end
    idrf_tvalid = 0;
    wb_vld = 1; wb_rd = 3; wb_data = 32'h55;
    tick();
    checks++; if (obs_tready !== 1'b0) begin errors++; $display("FAIL bp_tready_full: got %b expected 0", obs_tready); end
    wb_vld = 0;
    tick();
    checks++; if (obs_tdata !== exp_tdata || obs_tdata[TW-1:64] !== a) begin errors++; $display("FAIL bp_hold_a: got %h expected %h", obs_tdata, exp_tdata); end
    rfex_tready = 1;
    tick();
    checks++; if (obs_tdata[TW-1:64] !== a || obs_tvalid !== 1'b1) begin errors++; $display("FAIL bp_order_a: got %h expected id %h", obs_tdata, a); end
    tick();
    checks++; if (obs_tdata !== {b, 32'h55, 32'h0} || obs_tvalid !== 1'b1) begin errors++; $display("FAIL bp_refresh_b: got %h expected %h", obs_tdata, {b, 32'h55, 32'h0}); end
    tick();
    checks++; if (obs_tvalid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", obs_tvalid); end
  endtask

  task automatic test_x0_write();
    logic [ID_W-1:0] a;
    a = mk_id(5'd0, 5'd0);
    wb_vld = 1; wb_rd = 0; wb_data = 32'hFFFF_FFFF;
    idrf_tvalid = 1; idrf_tdata = a;
    tick();
    checks++; if (obs_tready !== 1'b1) begin errors++; $display("FAIL x0_tready: got %b expected 1", obs_tready); end
    wb_vld = 0; idrf_tvalid = 0;
    tick();
    checks++; if (obs_tdata !== {a, 64'h0}) begin errors++; $display("FAIL x0_same_cycle: got %h expected %h", obs_tdata, {a, 64'h0}); end
    idrf_tvalid = 1;
    tick();
    idrf_tvalid = 0;
    tick();
    checks++; if (obs_tdata !== {a, 64'h0} || obs_tvalid !== 1'b1) begin errors++; $display("FAIL x0_read: got %h expected %h", obs_tdata, {a, 64'h0}); end
    tick();
  endtask

  task automatic test_flush();
    logic [ID_W-1:0] a;
    rfex_tready = 0;
    idrf_tvalid = 1; idrf_tdata = mk_id(5'd5, 5'd0);
    tick();
    idrf_tdata = mk_id(5'd5, 5'd7);
    tick();
    idrf_tvalid = 0;
    tick();
    checks++; if (obs_tready !== 1'b0 || obs_tvalid !== 1'b1) begin errors++; $display("FAIL flush_full: got tready=%b tvalid=%b expected 0 1", obs_tready, obs_tvalid); end
    invalidate = 1; wb_vld = 1; wb_rd = 9; wb_data = 32'hA5A5_0009;
    tick();
    invalidate = 0; wb_vld = 0;
    tick();
    checks++; if (obs_tvalid !== 1'b0 || obs_tready !== 1'b1) begin errors++; $display("FAIL flush_clear: got tvalid=%b tready=%b expected 0 1", obs_tvalid, obs_tready); end
    rfex_tready = 1; invalidate = 1;
    idrf_tvalid = 1; idrf_tdata = mk_id(5'd1, 5'd2);
    tick();
    invalidate = 0; idrf_tvalid = 0;
    tick();
    checks++; if (obs_tvalid !== 1'b0) begin errors++; $display("FAIL flush_drop: got %b expected 0", obs_tvalid); end
    a = mk_id(5'd5, 5'd9);
    idrf_tvalid = 1; idrf_tdata = a;
    tick();
    idrf_tvalid = 0;
    tick();
    checks++; if (obs_tdata !== {a, 32'h1234_5678, 32'hA5A5_0009}) begin errors++; $display("FAIL flush_array: got %h expected %h", obs_tdata, {a, 32'h1234_5678, 32'hA5A5_0009}); end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 2000; n++) begin
      idrf_tvalid = ($urandom_range(0, 3) != 0);
      idrf_tdata  = mk_id(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      rfex_tready = ($urandom_range(0, 9) < 7);
      wb_vld      = $urandom_range(0, 1);
      wb_rd       = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      invalidate  = ($urandom_range(0, 99) < 3);
      tick();
      checks++; if (obs_tready !== exp_tready) begin errors++; $display("FAIL rnd_tready[%0d]: got %b expected %b", n, obs_tready, exp_tready); end
      checks++; if (obs_tvalid !== exp_tvalid) begin errors++; $display("FAIL rnd_tvalid[%0d]: got %b expected %b", n, obs_tvalid, exp_tvalid); end
      if (exp_tvalid) begin
        checks++; if (obs_tdata !== exp_tdata) begin errors++; $display("FAIL rnd_tdata[%0d]: got %h expected %h", n, obs_tdata, exp_tdata); end
      end
    end
    idrf_tvalid = 0; wb_vld = 0; invalidate = 0; rfex_tready = 1;
    repeat (3) tick();
    checks++; if (obs_tvalid !== 1'b0) begin errors++; $display("FAIL rnd_drain: got %b expected 0", obs_tvalid); end
  endtask

  initial begin
    test_reset();
    test_zero_read();
    test_writeback();
    test_same_cycle();
    test_back_to_back();
    test_x0_write();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
